pedal_mem_pipeline: RTL and testbench
=====================================

// Module: pedal_mem_pipeline
// PURPOSE
// Offline effect-processing pipeline for the pedal memory tests. Streams every word of an
// input sample RAM, in address order, through two cascaded registered gain stages and
// writes each result to the same address of an output sample RAM. A free-running cycle
// counter is exported for timing. Host ports load the input RAM and read back the output RAM.
// PARAMETERS
// DATA_W   16     sample width, two's-complement signed
// ADDR_W   16     address width of both RAMs
// DEPTH    65536  words per RAM; one pass processes addresses 0..DEPTH-1
// GAIN     256    per-stage gain, Q8.8 unsigned (256 = unity)
// PORTS
// clk          in   1       single clock, all logic on rising edge
// rst          in   1       synchronous, active-high reset
// en           in   1       1 = pipeline advances; 0 = whole pipeline stalls
// ld_we        in   1       host write strobe into input RAM
// ld_addr      in   ADDR_W  host write address (input RAM)
// ld_data      in   DATA_W  host write data (input RAM)
// rd_addr      in   ADDR_W  host read address (output RAM)
// rd_data      out  DATA_W  output RAM word at rd_addr, 1-cycle synchronous read
// count        out  16      free-running cycle counter
// done         out  1       pass complete, sticky until rst
// BEHAVIOUR
// - Reset (rst=1 at an edge): read address, stage valid bits, count, done <= 0; rd_data <= 0.
//   RAM contents are NOT reset. Reset mid-pass aborts; next pass restarts at address 0.
// - count: +1 every cycle regardless of en/done, wraps 16'hFFFF -> 0.
// - Read stage: while en=1 and issue address < DEPTH, input RAM read at rd_ptr (synchronous,
//   1 cycle), rd_ptr +1. After DEPTH-1 issued, no further reads; rd_ptr never wraps.
// - Stage 1 / stage 2 (each 1 registered cycle): y = sat((x * GAIN) >>> 8), signed product,
//   arithmetic shift, saturate to [-32768, 32767]. Valid bit travels with each word.
// - Write: when stage-2 word valid and en=1, output RAM[addr] <= y, addr = source address of
//   that word (address delayed 3 cycles alongside data). out_mem[A] = f(f(in_mem[A])).
// - Latency: address issued at edge k -> output RAM written at edge k+3.
// - en=0: every pipeline register, valid bit and rd_ptr holds; no RAM read/write issued by
//   pipeline; resuming en=1 continues with no lost or duplicated word.
// - done: set on the edge that writes address DEPTH-1; stays 1 until rst.
// - Host load to same input address the pipeline reads in the same cycle: read returns OLD data.
// - Host read of output address written same cycle: rd_data returns OLD data.
// - Host ports usable at any time, independent of en/done.
// TESTING
// - GAIN=256, DEPTH=8, in_mem[i]=i*100, en=1 -> out_mem[i]=i*100, done=1 exactly 3 cycles
//   after address 7 issued (11 cycles after first en edge).
// - GAIN=512, in_mem={16'h3000, 16'hE000, 16'h7FFF} -> out={16'h7FFF, 16'h8000, 16'h7FFF}
//   (x4 with saturation); GAIN=128, in 16'h0400 -> out 16'h0100.
// - en deasserted 5 cycles mid-pass -> outputs identical to uninterrupted run, done delayed
//   by exactly 5 cycles, count still advanced by 5.
// - rst asserted at address 4 -> done=0, count=0; rerun writes all DEPTH words correctly.
// - count run 65540 cycles from reset -> reads 4 (wrap check); done unaffected.
// - Host rd_addr sweep after done -> rd_data one cycle later equals expected out_mem.

Source files
------------

// File: rtl/pedal_mem_pipeline.sv
// Streams the input sample RAM through two saturating Q8.8 gain stages into the output RAM.
// Host ports load the input RAM and read the output RAM independently of the pass.
module pedal_mem_pipeline #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 65536,
    parameter int GAIN   = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              ld_we,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       count,
    output logic              done
);

    localparam int PW = DATA_W + 18;
    localparam logic signed [PW-1:0] GAIN_W  = PW'(GAIN);
    localparam logic signed [PW-1:0] SAT_MAX = {{(PW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [PW-1:0] SAT_MIN = {{(PW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic [ADDR_W:0]   END_PTR = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);

    function automatic logic [DATA_W-1:0] gain_sat(input logic [DATA_W-1:0] x);
        logic signed [PW-1:0] px;
        logic signed [PW-1:0] prod;
        px   = {{(PW-DATA_W){x[DATA_W-1]}}, x};
        prod = (px * GAIN_W) >>> 8;
        if (prod > SAT_MAX)
            return SAT_MAX[DATA_W-1:0];
        else if (prod < SAT_MIN)
            return SAT_MIN[DATA_W-1:0];
        else
            return prod[DATA_W-1:0];
    endfunction

    logic [DATA_W-1:0] in_mem  [DEPTH];
    logic [DATA_W-1:0] out_mem [DEPTH];

    // One extra pointer bit lets the read side stop at DEPTH instead of wrapping.
    logic [ADDR_W:0]   rd_ptr;
    logic              issue;
    logic              wr_en;
    logic              v0, v1, v2;
    logic [ADDR_W-1:0] a0, a1, a2;
    logic [DATA_W-1:0] d0, d1, d2;

    assign issue = en && (rd_ptr < END_PTR);
    assign wr_en = en && v2 && !rst;

    always_ff @(posedge clk) begin
        if (ld_we)
            in_mem[ld_addr] <= ld_data;
    end

    always_ff @(posedge clk) begin
        if (issue && !rst)
            d0 <= in_mem[rd_ptr[ADDR_W-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            v0     <= 1'b0;
            v1     <= 1'b0;
            v2     <= 1'b0;
            count  <= '0;
            done   <= 1'b0;
        end else begin
            count <= count + 16'd1;
            if (en) begin
                v0 <= issue;
                a0 <= rd_ptr[ADDR_W-1:0];
                if (issue)
                    rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
                v1 <= v0;
                a1 <= a0;
                d1 <= gain_sat(d0);
                v2 <= v1;
                a2 <= a1;
                d2 <= gain_sat(d1);
                if (v2 && a2 == LAST)
                    done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            out_mem[a2] <= d2;
    end

    // Host read sees the pre-write word when it collides with a pipeline write.
    always_ff @(posedge clk) begin
        if (rst)
            rd_data <= '0;
        else
            rd_data <= out_mem[rd_addr];
    end

endmodule

// File: tb/tb_pedal_mem_pipeline.sv
// Bench for pedal_mem_pipeline: three 8-word instances at gains 1.0, 2.0 and 0.5 run in lockstep;
// readback expectations are queued when rd_addr is driven and popped when rd_data is sampled.
module tb_pedal_mem_pipeline;

    localparam int D = 8;

    logic        clk = 1'b0;
    logic        rst, en, ld_we;
    logic [2:0]  ld_addr, rd_addr;
    logic [15:0] ld_data;
    logic [15:0] rd_data_u, rd_data_x2, rd_data_h;
    logic [15:0] count_u, count_x2, count_h;
    logic        done_u, done_x2, done_h;

    logic [15:0] in_shadow [D];
    logic [15:0] q_u[$], q_x2[$], q_h[$];
    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pedal_mem_pipeline #(.DATA_W(16), .ADDR_W(3), .DEPTH(D), .GAIN(256)) dut_u (
        .clk(clk), .rst(rst), .en(en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data_u), .count(count_u), .done(done_u));
    pedal_mem_pipeline #(.DATA_W(16), .ADDR_W(3), .DEPTH(D), .GAIN(512)) dut_x2 (
        .clk(clk), .rst(rst), .en(en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data_x2), .count(count_x2), .done(done_x2));
    pedal_mem_pipeline #(.DATA_W(16), .ADDR_W(3), .DEPTH(D), .GAIN(128)) dut_h (
        .clk(clk), .rst(rst), .en(en), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data_h), .count(count_h), .done(done_h));

    function automatic logic [15:0] stage(input logic [15:0] x, input int g);
        int p;
        p = int'($signed(x)) * g;
        p = p >>> 8;
        if (p > 32767)  p = 32767;
        if (p < -32768) p = -32768;
        return p[15:0];
    endfunction

    function automatic logic [15:0] model(input logic [15:0] x, input int g);
        return stage(stage(x, g), g);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load_word(input logic [2:0] a, input logic [15:0] v);
        ld_we   = 1'b1;
        ld_addr = a;
        ld_data = v;
        in_shadow[a] = v;
        tick();
        ld_we = 1'b0;
    endtask

    task automatic load_ramp(input int base, input int step);
        for (int i = 0; i < D; i++)
            load_word(3'(i), 16'(base + i * step));
    endtask

    task automatic run_pass(output int ticks, output bit ok);
        en = 1'b1;
        ticks = 0;
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            tick();
            ticks++;
            if (done_u) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_readback(input string tag);
        logic [15:0] e;
        en = 1'b0;
        for (int a = 0; a < D; a++) begin
            rd_addr = 3'(a);
            q_u.push_back(model(in_shadow[a], 256));
            q_x2.push_back(model(in_shadow[a], 512));
            q_h.push_back(model(in_shadow[a], 128));
            tick();
            e = q_u.pop_front();
            n_total++;
            if (rd_data_u !== e) $display("FAIL %s_u addr=%0d got=%h exp=%h", tag, a, rd_data_u, e);
            else n_pass++;
            e = q_x2.pop_front();
            n_total++;
            if (rd_data_x2 !== e) $display("FAIL %s_x2 addr=%0d got=%h exp=%h", tag, a, rd_data_x2, e);
            else n_pass++;
            e = q_h.pop_front();
            n_total++;
            if (rd_data_h !== e) $display("FAIL %s_h addr=%0d got=%h exp=%h", tag, a, rd_data_h, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        tick();
        n_total++;
        if (count_u !== 16'd0 || count_x2 !== 16'd0 || count_h !== 16'd0)
            $display("FAIL reset_count got=%h/%h/%h exp=0", count_u, count_x2, count_h);
        else n_pass++;
        n_total++;
        if ({done_u, done_x2, done_h} !== 3'b000)
            $display("FAIL reset_done got=%b%b%b exp=000", done_u, done_x2, done_h);
        else n_pass++;
        n_total++;
        if (rd_data_u !== 16'd0 || rd_data_x2 !== 16'd0 || rd_data_h !== 16'd0)
            $display("FAIL reset_rd_data got=%h/%h/%h exp=0", rd_data_u, rd_data_x2, rd_data_h);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_unity();
        int t;
        bit ok;
        en = 1'b0;
        load_ramp(0, 100);
        reset_dut();
        run_pass(t, ok);
        n_total++;
        if (!ok || t != 11) $display("FAIL unity_done_latency got=%0d ok=%0d exp=11", t, ok);
        else n_pass++;
        n_total++;
        if (count_u !== 16'd11) $display("FAIL unity_count got=%0d exp=11", count_u);
        else n_pass++;
        n_total++;
        if (!(done_x2 && done_h)) $display("FAIL unity_done_all got=%b%b exp=11", done_x2, done_h);
        else n_pass++;
        test_readback("unity");
    endtask

    task automatic test_gain();
        logic [15:0] vals [D];
        logic [15:0] exp_x2 [3];
        int t;
        bit ok;
        vals = '{16'h3000, 16'hE000, 16'h7FFF, 16'h0400, 16'hFFFF, 16'h8000, 16'h0001, 16'h0100};
        exp_x2 = '{16'h7FFF, 16'h8000, 16'h7FFF};
        en = 1'b0;
        for (int i = 0; i < D; i++) load_word(3'(i), vals[i]);
        reset_dut();
        run_pass(t, ok);
        n_total++;
        if (!ok || t != 11) $display("FAIL gain_done_latency got=%0d ok=%0d exp=11", t, ok);
        else n_pass++;
        test_readback("gain");
        for (int a = 0; a < 3; a++) begin
            rd_addr = 3'(a);
            tick();
            n_total++;
            if (rd_data_x2 !== exp_x2[a]) $display("FAIL gain_x4_sat addr=%0d got=%h exp=%h", a, rd_data_x2, exp_x2[a]);
            else n_pass++;
        end
        rd_addr = 3'd3;
        tick();
        n_total++;
        if (rd_data_h !== 16'h0100) $display("FAIL gain_quarter got=%h exp=0100", rd_data_h);
        else n_pass++;
    endtask

    task automatic test_stall();
        int t;
        bit ok;
        en = 1'b0;
        load_ramp(-300, 100);
        reset_dut();
        en = 1'b1;
        repeat (3) tick();
        en = 1'b0;
        repeat (5) begin
            tick();
            n_total++;
            if (done_u !== 1'b0) $display("FAIL stall_done_early got=%b exp=0", done_u);
            else n_pass++;
        end
        run_pass(t, ok);
        n_total++;
        if (!ok || 8 + t != 16) $display("FAIL stall_done_latency got=%0d ok=%0d exp=16", 8 + t, ok);
        else n_pass++;
        n_total++;
        if (count_u !== 16'd16) $display("FAIL stall_count got=%0d exp=16", count_u);
        else n_pass++;
        test_readback("stall");
    endtask

    task automatic test_rst_mid();
        int t;
        bit ok;
        en = 1'b0;
        reset_dut();
        en = 1'b1;
        repeat (5) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        en = 1'b0;
        n_total++;
        if ({done_u, done_x2, done_h} !== 3'b000) $display("FAIL rstmid_done got=%b exp=0", done_u);
        else n_pass++;
        n_total++;
        if (count_u !== 16'd0) $display("FAIL rstmid_count got=%0d exp=0", count_u);
        else n_pass++;
        load_ramp(77, -1234);
        run_pass(t, ok);
        n_total++;
        if (!ok || t != 11) $display("FAIL rstmid_rerun_latency got=%0d ok=%0d exp=11", t, ok);
        else n_pass++;
        test_readback("rstmid");
    endtask

    task automatic test_back_to_back();
        logic [15:0] old_u, old_x2, new_u;
        int t;
        bit ok;
        old_u  = model(in_shadow[7], 256);
        old_x2 = model(in_shadow[7], 512);
        en = 1'b0;
        load_ramp(-1000, 311);
        load_word(3'd0, 16'd500);
        new_u = model(in_shadow[7], 256);
        reset_dut();
        rd_addr = 3'd7;
        en = 1'b1;
        ld_we = 1'b1; ld_addr = 3'd0; ld_data = 16'd900;
        tick();
        ld_we = 1'b0;
        run_pass(t, ok);
        n_total++;
        if (!ok || 1 + t != 11) $display("FAIL b2b_done_latency got=%0d ok=%0d exp=11", 1 + t, ok);
        else n_pass++;
        n_total++;
        if (rd_data_u !== old_u || rd_data_x2 !== old_x2)
            $display("FAIL b2b_rd_old got=%h/%h exp=%h/%h", rd_data_u, rd_data_x2, old_u, old_x2);
        else n_pass++;
        tick();
        n_total++;
        if (rd_data_u !== new_u) $display("FAIL b2b_rd_new got=%h exp=%h", rd_data_u, new_u);
        else n_pass++;
        test_readback("b2b");
    endtask

    task automatic test_count_wrap();
        en = 1'b0;
        reset_dut();
        en = 1'b1;
        repeat (65540) tick();
        n_total++;
        if (count_u !== 16'd4) $display("FAIL wrap_count got=%0d exp=4", count_u);
        else n_pass++;
        n_total++;
        if (done_u !== 1'b1) $display("FAIL wrap_done got=%b exp=1", done_u);
        else n_pass++;
        en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unity();
        test_gain();
        test_stall();
        test_rst_mid();
        test_back_to_back();
        test_count_wrap();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
